// File: rtl/vcb_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// vcb_mod_counter_pkg
//   Shared constants for the modulo-N counter family: direction and mode
//   encodings plus the compile-time check that a modulus fits its width.
//   No ports; imported by vcb_tc_cmp and vcb_mod_counter.
// ---------------------------------------------------------------------------
package vcb_mod_counter_pkg;

  // Direction encoding for the 'up' input
  localparam logic VCB_DN = 1'b0;
  localparam logic VCB_UP = 1'b1;

  // Mode encoding for the 'oneshot' input
  localparam logic VCB_PERIODIC = 1'b0;
  localparam logic VCB_ONESHOT  = 1'b1;

  // A modulus is usable when it has at least two states and all of
  // 0..m-1 are representable in w bits.
  function automatic bit moduloInRange(input int w, input int m);
    return (m >= 2) && (longint'(m) <= (longint'(1) << w));
  endfunction

endpackage

// File: rtl/vcb_tc_cmp.sv
// ---------------------------------------------------------------------------
// vcb_tc_cmp
//   Combinational terminal-count detector, shared by the counter's
//   next-state logic and its TC/CEO outputs.
// Ports:
//   q      in  W  current counter value
//   up     in  1  direction (1 = up, 0 = down)
//   at_max out 1  q equals MODULO-1
//   at_min out 1  q equals 0
//   TC     out 1  terminal count for the current direction
// ---------------------------------------------------------------------------
module vcb_tc_cmp
  import vcb_mod_counter_pkg::*;
#(
  parameter int W      = 4,
  parameter int MODULO = 16
) (
  input  logic [W-1:0] q,
  input  logic         up,
  output logic         at_max,
  output logic         at_min,
  output logic         TC
);

  localparam logic [W-1:0] LP_MAX = W'(MODULO - 1);

  // Terminal is the top of the range when counting up and zero when
  // counting down; it follows 'up' with no register in between.
  always_comb begin
    at_max = (q == LP_MAX);
    at_min = (q == '0);
    TC     = (up == VCB_UP) ? at_max : at_min;
  end

endmodule

// File: rtl/vcb_mod_counter.sv
// ---------------------------------------------------------------------------
// vcb_mod_counter
//   Parametrised modulo-N up/down counter with clock enable, synchronous
//   set, saturating parallel load and a periodic / one-shot mode. TC and
//   CEO allow ripple-enable cascading into multi-digit counters.
// Ports:
//   clk     in  1  clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   ce      in  1  count enable
//   s       in  1  synchronous set to MODULO-1 (highest priority)
//   load    in  1  synchronous load of din (saturated to MODULO-1)
//   din     in  W  load value
//   up      in  1  1 = count up, 0 = count down
//   oneshot in  1  1 = stop at terminal count, 0 = wrap
//   Q       out W  counter value
//   TC      out 1  terminal count (combinational)
//   CEO     out 1  cascade enable = ce & TC & ~DONE (combinational)
//   DONE    out 1  one-shot finished flag (registered)
// ---------------------------------------------------------------------------
module vcb_mod_counter
  import vcb_mod_counter_pkg::*;
#(
  parameter int W      = 4,
  parameter int MODULO = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         s,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         up,
  input  logic         oneshot,
  output logic [W-1:0] Q,
  output logic         TC,
  output logic         CEO,
  output logic         DONE
);

  localparam logic [W-1:0] LP_MAX = W'(MODULO - 1);
  localparam logic [W-1:0] LP_ONE = W'(1);

  // Reject moduli that cannot be represented or would give a single state.
  generate
    if (!moduloInRange(W, MODULO)) begin : g_badModulo
      $error("vcb_mod_counter: MODULO must satisfy 2 <= MODULO <= 2**W");
    end
  endgenerate

  logic [W-1:0] r_q;
  logic         r_done;
  logic [W-1:0] w_qNext;
  logic         w_doneNext;
  logic         w_atMax;
  logic         w_atMin;
  logic         w_tc;
  logic         w_countEn;

  vcb_tc_cmp #(
    .W      (W),
    .MODULO (MODULO)
  ) u_tcCmp (
    .q      (r_q),
    .up     (up),
    .at_max (w_atMax),
    .at_min (w_atMin),
    .TC     (w_tc)
  );

  // A finished one-shot ignores ce until it is re-armed by s, load or a
  // return to periodic mode.
  assign w_countEn = ce & ~r_done;

  // Next-state selection in priority order s > load > count > hold.
  // Wrapping is an explicit compare-and-select, so moduli that are not a
  // power of two never rely on natural overflow of the register width.
  always_comb begin
    w_qNext    = r_q;
    w_doneNext = r_done;
    if (s) begin
      w_qNext    = LP_MAX;
      w_doneNext = 1'b0;
    end else if (load) begin
      w_qNext    = (din > LP_MAX) ? LP_MAX : din;
      w_doneNext = 1'b0;
    end else begin
      if (oneshot == VCB_PERIODIC) begin
        w_doneNext = 1'b0;
      end
      if (w_countEn) begin
        if ((oneshot == VCB_ONESHOT) && w_tc) begin
          w_doneNext = 1'b1;
        end else if (up == VCB_UP) begin
          w_qNext = w_atMax ? '0 : (r_q + LP_ONE);
        end else begin
          w_qNext = w_atMin ? LP_MAX : (r_q - LP_ONE);
        end
      end
    end
  end

  // State registers; reset abandons any one-shot in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_qNext;
      r_done <= w_doneNext;
    end
  end

  assign Q    = r_q;
  assign DONE = r_done;
  assign TC   = w_tc;
  assign CEO  = ce & w_tc & ~r_done;

endmodule

// File: tb/tb_vcb_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_vcb_mod_counter
//   Directed self-checking bench for vcb_mod_counter (W=4, MODULO=10).
//   A second instance is cascaded from the first instance's CEO so the
//   two-digit decimal count can be checked as well.
// ---------------------------------------------------------------------------
module tb_vcb_mod_counter;

  logic       clock;
  logic       rstN;
  logic       ce;
  logic       s;
  logic       load;
  logic [3:0] din;
  logic       up;
  logic       oneshot;
  logic [3:0] loQ;
  logic       loTc;
  logic       loCeo;
  logic       loDone;
  logic [3:0] hiQ;
  logic       hiTc;
  logic       hiCeo;
  logic       hiDone;

  int checkCount;
  int errorCount;

  // Low digit: driven directly by the bench
  vcb_mod_counter #(
    .W      (4),
    .MODULO (10)
  ) dut (
    .clk     (clock),
    .rst_n   (rstN),
    .ce      (ce),
    .s       (s),
    .load    (load),
    .din     (din),
    .up      (up),
    .oneshot (oneshot),
    .Q       (loQ),
    .TC      (loTc),
    .CEO     (loCeo),
    .DONE    (loDone)
  );

  // High digit: enabled only by the low digit's cascade output
  vcb_mod_counter #(
    .W      (4),
    .MODULO (10)
  ) dutHi (
    .clk     (clock),
    .rst_n   (rstN),
    .ce      (loCeo),
    .s       (1'b0),
    .load    (1'b0),
    .din     (4'd0),
    .up      (up),
    .oneshot (oneshot),
    .Q       (hiQ),
    .TC      (hiTc),
    .CEO     (hiCeo),
    .DONE    (hiDone)
  );

  // Free-running clock, 10 time-unit period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  int expQ2[11] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
  int ceSeq3[4] = '{0, 1, 0, 1};
  int expQ3[4]  = '{8, 9, 9, 0};
  int expCeo3[4] = '{0, 0, 0, 1};
  int expQ5[4]  = '{1, 0, 0, 0};
  int expDone5[4] = '{0, 0, 1, 1};
  int expCeo5[4] = '{0, 0, 1, 0};

  initial begin
    checkCount = 0;
    errorCount = 0;
    rstN = 1'b0;
    ce = 1'b0; s = 1'b0; load = 1'b0; din = 4'd0;
    up = 1'b0; oneshot = 1'b0;

    // ---- reset state ----
    #2;
    checkOutput("reset_q", 32'(loQ), 0);
    checkOutput("reset_done", 32'(loDone), 0);
    @(negedge clock);
    rstN = 1'b1;

    // ---- 1: async reset mid-count ----
    s = 1'b1;
    applyStimulus();
    s = 1'b0; ce = 1'b1; up = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("t1_q7", 32'(loQ), 7);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t1_async_q", 32'(loQ), 0);
    checkOutput("t1_async_done", 32'(loDone), 0);
    checkOutput("t1_async_tc", 32'(loTc), 1);
    ce = 1'b0;
    #1;
    rstN = 1'b1;

    // ---- 2: periodic down count with wrap ----
    s = 1'b1;
    applyStimulus();
    checkOutput("t2_set", 32'(loQ), 9);
    s = 1'b0; ce = 1'b1; up = 1'b0; oneshot = 1'b0;
    for (int i = 0; i < 11; i++) begin
      #1;
      checkOutput($sformatf("t2_ceo%0d", i), 32'(loCeo), (i == 9) ? 1 : 0);
      applyStimulus();
      checkOutput($sformatf("t2_q%0d", i), 32'(loQ), expQ2[i]);
    end

    // ---- 3: up count with toggling ce ----
    ce = 1'b0; load = 1'b1; din = 4'd8; up = 1'b1;
    applyStimulus();
    load = 1'b0;
    checkOutput("t3_load8", 32'(loQ), 8);
    for (int i = 0; i < 4; i++) begin
      ce = ceSeq3[i][0];
      #1;
      checkOutput($sformatf("t3_ceo%0d", i), 32'(loCeo), expCeo3[i]);
      applyStimulus();
      checkOutput($sformatf("t3_q%0d", i), 32'(loQ), expQ3[i]);
    end

    // ---- 4: saturating load and priorities ----
    ce = 1'b0; load = 1'b1; din = 4'd12;
    applyStimulus();
    checkOutput("t4_sat", 32'(loQ), 9);
    din = 4'd3;
    applyStimulus();
    checkOutput("t4_load3", 32'(loQ), 3);
    s = 1'b1; din = 4'd5;
    applyStimulus();
    checkOutput("t4_s_beats_load", 32'(loQ), 9);
    s = 1'b0; din = 4'd3; ce = 1'b1; up = 1'b1;
    applyStimulus();
    checkOutput("t4_load_beats_ce", 32'(loQ), 3);
    load = 1'b0; ce = 1'b0;

    // ---- 5: one-shot down count ----
    oneshot = 1'b1; load = 1'b1; din = 4'd2;
    applyStimulus();
    load = 1'b0; ce = 1'b1; up = 1'b0;
    checkOutput("t5_load2", 32'(loQ), 2);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("t5_ceo%0d", i), 32'(loCeo), expCeo5[i]);
      applyStimulus();
      checkOutput($sformatf("t5_q%0d", i), 32'(loQ), expQ5[i]);
      checkOutput($sformatf("t5_done%0d", i), 32'(loDone), expDone5[i]);
    end
    checkOutput("t5_tc_held", 32'(loTc), 1);
    up = 1'b1;
    #1;
    checkOutput("t5_tc_up", 32'(loTc), 0);
    checkOutput("t5_ceo_up", 32'(loCeo), 0);
    up = 1'b0;
    load = 1'b1; din = 4'd5;
    applyStimulus();
    checkOutput("t5_reload_q", 32'(loQ), 5);
    checkOutput("t5_reload_done", 32'(loDone), 0);
    din = 4'd0;
    applyStimulus();
    load = 1'b0;
    applyStimulus();
    checkOutput("t5_done_again", 32'(loDone), 1);
    oneshot = 1'b0; ce = 1'b0;
    applyStimulus();
    checkOutput("t5_periodic_clear", 32'(loDone), 0);
    checkOutput("t5_periodic_q", 32'(loQ), 0);

    // ---- 6: two-digit cascade 00..99..00 ----
    rstN = 1'b0;
    #1;
    rstN = 1'b1;
    up = 1'b1; oneshot = 1'b0; ce = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      checkOutput($sformatf("t6_hiceo%0d", i), 32'(hiCeo), (i == 99) ? 1 : 0);
      applyStimulus();
      checkOutput($sformatf("t6_count%0d", i), 32'({hiQ, loQ}),
                  32'((((i + 1) % 100) / 10) * 16 + ((i + 1) % 10)));
    end
    ce = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
